// File: rtl/set_assoc_cache.sv
// ---------------------------------------------------------------------------
// set_assoc_cache
//   N-way set-associative, write-back, write-allocate cache with per-set
//   true-LRU replacement. It handles one outstanding requester transaction
//   at a time. Misses do a full-block writeback of a dirty victim, then a
//   full-block line fill through a blocking req/ack memory handshake.
//
// Optional feature macro: CACHE_STATS_EN
//   Adds hit_cnt / miss_cnt (32-bit, saturating) counting completed requests.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata   requester command (accepted on cpu_req & cpu_ready)
//   cpu_ready       high only while idle
//   cpu_ack         one-cycle completion pulse
//   cpu_rdata       read data, valid with cpu_ack, held otherwise
//   cpu_hit         1 if the first lookup of the request hit
//   mem_req/we/addr/wdata   memory command, held stable until mem_ack
//   mem_rdata       fill block, sampled on the mem_ack edge
//   mem_ack         completes the current memory command
//   hit_cnt, miss_cnt   (CACHE_STATS_EN only) completion statistics
// ---------------------------------------------------------------------------
module set_assoc_cache #(
    parameter int SETS       = 16,
    parameter int WAYS       = 4,
    parameter int WORDS      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [ADDR_WIDTH-1:0]         cpu_addr,
    input  logic [DATA_WIDTH-1:0]         cpu_wdata,
    output logic                          cpu_ready,
    output logic                          cpu_ack,
    output logic [DATA_WIDTH-1:0]         cpu_rdata,
    output logic                          cpu_hit,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH*WORDS-1:0]   mem_wdata,
    input  logic [DATA_WIDTH*WORDS-1:0]   mem_rdata,
    input  logic                          mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                   hit_cnt,
    output logic [31:0]                   miss_cnt
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(WORDS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int BLK_W = DATA_WIDTH * WORDS;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOOKUP    = 2'd1;
    localparam logic [1:0] ST_WRITEBACK = 2'd2;
    localparam logic [1:0] ST_FILL      = 2'd3;

    // Line storage
    logic                  valid_r [SETS][WAYS];
    logic                  dirty_r [SETS][WAYS];
    logic [TAG_W-1:0]      tag_r   [SETS][WAYS];
    logic [WAY_W-1:0]      age_r   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_r  [SETS][WAYS][WORDS];

    // Control state and latched request
    logic [1:0]            state_r;
    logic                  req_we_r;
    logic [ADDR_WIDTH-1:0] req_addr_r;
    logic [DATA_WIDTH-1:0] req_wdata_r;
    logic                  first_r;      // still on the first lookup of this request
    logic [WAY_W-1:0]      victim_r;

    // Registered outputs
    logic                  cpu_ready_r;
    logic                  cpu_ack_r;
    logic [DATA_WIDTH-1:0] cpu_rdata_r;
    logic                  cpu_hit_r;
    logic                  mem_req_r;
    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [BLK_W-1:0]      mem_wdata_r;

    // Lookup results
    logic [TAG_W-1:0]      req_tag_s;
    logic [IDX_W-1:0]      idx_s;
    logic [OFF_W-1:0]      off_s;
    logic                  hit_s;
    logic [WAY_W-1:0]      hit_way_s;
    logic [WAY_W-1:0]      hit_age_s;
    logic                  inv_found_s;
    logic [WAY_W-1:0]      inv_way_s;
    logic [WAY_W-1:0]      lru_way_s;
    logic [WAY_W-1:0]      victim_s;
    logic [BLK_W-1:0]      victim_block_s;

    assign req_tag_s = req_addr_r[ADDR_WIDTH-1 -: TAG_W];
    assign idx_s     = req_addr_r[OFF_W +: IDX_W];
    assign off_s     = req_addr_r[OFF_W-1:0];

    // Tag compare, victim choice (lowest invalid way, else the LRU way) and victim block packing
    always_comb begin
        hit_s          = 1'b0;
        hit_way_s      = {WAY_W{1'b0}};
        inv_found_s    = 1'b0;
        inv_way_s      = {WAY_W{1'b0}};
        lru_way_s      = {WAY_W{1'b0}};
        victim_block_s = {BLK_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            hit_way_s = (valid_r[idx_s][w] && (tag_r[idx_s][w] == req_tag_s)) ? WAY_W'(w) : hit_way_s;
            hit_s     = hit_s | (valid_r[idx_s][w] && (tag_r[idx_s][w] == req_tag_s));
            lru_way_s = (age_r[idx_s][w] == WAY_W'(WAYS - 1)) ? WAY_W'(w) : lru_way_s;
        end
        // Descending scan so the lowest-index invalid way wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            inv_way_s   = (!valid_r[idx_s][w]) ? WAY_W'(w) : inv_way_s;
            inv_found_s = inv_found_s | !valid_r[idx_s][w];
        end
        victim_s  = inv_found_s ? inv_way_s : lru_way_s;
        hit_age_s = age_r[idx_s][hit_way_s];
        for (int k = 0; k < WORDS; k++) begin
            victim_block_s[k*DATA_WIDTH +: DATA_WIDTH] = data_r[idx_s][victim_s][k];
        end
    end

    // Main controller: request handshake, lookup, writeback/fill sequencing and line updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[s][w] <= 1'b0;
                    dirty_r[s][w] <= 1'b0;
                    tag_r[s][w]   <= {TAG_W{1'b0}};
                    age_r[s][w]   <= WAY_W'(w);
                    for (int k = 0; k < WORDS; k++) begin
                        data_r[s][w][k] <= {DATA_WIDTH{1'b0}};
                    end
                end
            end
            state_r     <= ST_IDLE;
            req_we_r    <= 1'b0;
            req_addr_r  <= {ADDR_WIDTH{1'b0}};
            req_wdata_r <= {DATA_WIDTH{1'b0}};
            first_r     <= 1'b0;
            victim_r    <= {WAY_W{1'b0}};
            cpu_ready_r <= 1'b1;
            cpu_ack_r   <= 1'b0;
            cpu_rdata_r <= {DATA_WIDTH{1'b0}};
            cpu_hit_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {BLK_W{1'b0}};
        end else begin
            cpu_ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cpu_req) begin
                        req_we_r    <= cpu_we;
                        req_addr_r  <= cpu_addr;
                        req_wdata_r <= cpu_wdata;
                        first_r     <= 1'b1;
                        cpu_ready_r <= 1'b0;
                        state_r     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit_s) begin
                        if (req_we_r) begin
                            data_r[idx_s][hit_way_s][off_s] <= req_wdata_r;
                            dirty_r[idx_s][hit_way_s]       <= 1'b1;
                        end else begin
                            cpu_rdata_r <= data_r[idx_s][hit_way_s][off_s];
                        end
                        // Hit way becomes MRU; younger ways age by one, older ones keep their age
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way_s) begin
                                age_r[idx_s][w] <= {WAY_W{1'b0}};
                            end else if (age_r[idx_s][w] < hit_age_s) begin
                                age_r[idx_s][w] <= age_r[idx_s][w] + WAY_W'(1);
                            end
                        end
                        if (first_r) begin
                            cpu_hit_r <= 1'b1;
                        end
                        cpu_ack_r   <= 1'b1;
                        cpu_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        first_r   <= 1'b0;
                        cpu_hit_r <= 1'b0;
                        victim_r  <= victim_s;
                        mem_req_r <= 1'b1;
                        if (valid_r[idx_s][victim_s] && dirty_r[idx_s][victim_s]) begin
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= {tag_r[idx_s][victim_s], idx_s, {OFF_W{1'b0}}};
                            mem_wdata_r <= victim_block_s;
                            state_r     <= ST_WRITEBACK;
                        end else begin
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= {req_tag_s, idx_s, {OFF_W{1'b0}}};
                            state_r    <= ST_FILL;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack) begin
                        dirty_r[idx_s][victim_r] <= 1'b0;
                        // mem_req drops for one cycle before the fill is issued
                        mem_req_r <= 1'b0;
                        state_r   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!mem_req_r) begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {req_tag_s, idx_s, {OFF_W{1'b0}}};
                    end else if (mem_ack) begin
                        for (int k = 0; k < WORDS; k++) begin
                            data_r[idx_s][victim_r][k] <= mem_rdata[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        valid_r[idx_s][victim_r] <= 1'b1;
                        dirty_r[idx_s][victim_r] <= 1'b0;
                        tag_r[idx_s][victim_r]   <= req_tag_s;
                        mem_req_r <= 1'b0;
                        // Replay the lookup; it now hits and finishes as a hit
                        state_r   <= ST_LOOKUP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cpu_ready_r <= 1'b1;
                    mem_req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ready = cpu_ready_r;
    assign cpu_ack   = cpu_ack_r;
    assign cpu_rdata = cpu_rdata_r;
    assign cpu_hit   = cpu_hit_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Saturating completion counters, sampled while the ack pulse is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if (cpu_ack_r) begin
            if (cpu_hit_r) begin
                if (hit_cnt_r != 32'hFFFF_FFFF) begin
                    hit_cnt_r <= hit_cnt_r + 32'd1;
                end
            end else begin
                if (miss_cnt_r != 32'hFFFF_FFFF) begin
                    miss_cnt_r <= miss_cnt_r + 32'd1;
                end
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// ---------------------------------------------------------------------------
// tb_set_assoc_cache
//   Directed bench for set_assoc_cache (default parameters). A behavioural
//   model (golden memory image plus per-set MRU-ordered tag lists) predicts
//   each completion and each memory transaction; one compare process checks
//   them, and literal expectations pin the model for the key scenarios.
// ---------------------------------------------------------------------------
module tb_set_assoc_cache;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = 16'h0000;
    logic [DW-1:0] cpu_wdata = 32'h0;
    logic          cpu_ready, cpu_ack, cpu_hit;
    logic [DW-1:0] cpu_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic [BW-1:0] mem_rdata = 128'h0;
    logic          mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0]   hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    set_assoc_cache #(.SETS(16), .WAYS(4), .WORDS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    typedef struct {
        logic        hit;
        logic [31:0] rdata;
        logic        is_read;
    } cpu_exp_t;

    typedef struct {
        logic          we;
        logic [15:0]   addr;
        logic [127:0]  data;
    } mem_t;

    int checks = 0;
    int errors = 0;

    cpu_exp_t exp_cpu[$];
    mem_t     exp_mem[$];
    mem_t     txn_log[$];

    logic [31:0] gold   [0:65535];   // what every address must read as
    logic [31:0] mem_bk [0:65535];   // contents of the backing memory
    logic [9:0]  m_tag   [16][4];    // resident tags per set, index 0 = MRU
    logic        m_dirty [16][4];
    int          m_cnt   [16];

    logic mem_hold = 1'b0;
    int   txn = 0;
    int   wait_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] gold_block(input logic [15:0] base);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = gold[base + 16'(k)];
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_cnt[s] = 0;
            for (int i = 0; i < 4; i++) m_dirty[s][i] = 1'b0;
        end
        for (int a = 0; a < 65536; a++) gold[a] = mem_bk[a];
        exp_cpu.delete();
        exp_mem.delete();
    endtask

    // Predict the outcome of one access from LRU-list semantics and the golden image
    task automatic model_access(input logic we, input logic [15:0] addr, input logic [31:0] wd);
        int          s, pos;
        logic [3:0]  sx;
        logic [9:0]  t, tt;
        logic        dd, hitv;
        mem_t        e;
        cpu_exp_t    c;
        sx = addr[5:2];
        s = int'(sx);
        t = addr[15:6];
        pos = -1;
        for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) pos = i;
        if (pos < 0) begin
            hitv = 1'b0;
            if (m_cnt[s] == 4) begin
                if (m_dirty[s][3]) begin
                    e.we = 1'b1;
                    e.addr = {m_tag[s][3], sx, 2'b00};
                    e.data = gold_block(e.addr);
                    exp_mem.push_back(e);
                end
                m_cnt[s] = 3;
            end
            e.we = 1'b0;
            e.addr = {t, sx, 2'b00};
            e.data = 128'h0;
            exp_mem.push_back(e);
            for (int i = m_cnt[s]; i > 0; i--) begin
                m_tag[s][i] = m_tag[s][i-1];
                m_dirty[s][i] = m_dirty[s][i-1];
            end
            m_tag[s][0] = t;
            m_dirty[s][0] = 1'b0;
            m_cnt[s]++;
        end else begin
            hitv = 1'b1;
            tt = m_tag[s][pos];
            dd = m_dirty[s][pos];
            for (int i = pos; i > 0; i--) begin
                m_tag[s][i] = m_tag[s][i-1];
                m_dirty[s][i] = m_dirty[s][i-1];
            end
            m_tag[s][0] = tt;
            m_dirty[s][0] = dd;
        end
        if (we) begin
            m_dirty[s][0] = 1'b1;
            gold[addr] = wd;
        end
        c.hit = hitv;
        c.rdata = gold[addr];
        c.is_read = !we;
        exp_cpu.push_back(c);
    endtask

    // Memory responder: acks after 0,1,2 idle cycles in rotation, serves fills from mem_bk
    initial begin : responder
        mem_t t;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                wait_cnt = 0;
            end else if (mem_req && !mem_hold && !rst) begin
                if (wait_cnt >= (txn % 3)) begin
                    t.we = mem_we;
                    t.addr = mem_addr;
                    t.data = mem_wdata;
                    if (mem_we) begin
                        for (int k = 0; k < 4; k++) mem_bk[mem_addr + 16'(k)] = mem_wdata[k*32 +: 32];
                    end else begin
                        for (int k = 0; k < 4; k++) mem_rdata[k*32 +: 32] = mem_bk[mem_addr + 16'(k)];
                        t.data = mem_rdata;
                    end
                    txn_log.push_back(t);
                    txn++;
                    mem_ack = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Compare process: every memory ack cycle and every cpu_ack cycle against the model
    initial begin : compare
        mem_t     e;
        cpu_exp_t c;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (mem_req && mem_ack) begin
                    if (exp_mem.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem_txn: got we=%0b addr=%0h, expected none", mem_we, mem_addr);
                    end else begin
                        e = exp_mem.pop_front();
                        chk("mem_we", {127'h0, mem_we}, {127'h0, e.we});
                        chk("mem_addr", {112'h0, mem_addr}, {112'h0, e.addr});
                        if (e.we) chk("mem_wdata", mem_wdata, e.data);
                    end
                end
                if (cpu_ack) begin
                    if (exp_cpu.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cpu_ack: got ack=1, expected 0");
                    end else begin
                        c = exp_cpu.pop_front();
                        chk("cpu_hit", {127'h0, cpu_hit}, {127'h0, c.hit});
                        if (c.is_read) chk("cpu_rdata", {96'h0, cpu_rdata}, {96'h0, c.rdata});
                    end
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                          output logic hit, output logic [31:0] rd, output int lat);
        int n;
        model_access(we, addr, wd);
        n = 0;
        @(negedge clk);
        while (!cpu_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        lat = 0;
        while (!cpu_ack && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!cpu_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack", lat);
        end
        hit = cpu_hit;
        rd = cpu_rdata;
        chk("ready_at_ack", {127'h0, cpu_ready}, 128'h1);
        chk("mem_txns_drained", 128'(exp_mem.size()), 128'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic        h;
    logic [31:0] rd;
    int          lat;
    int          n;

    initial begin
        for (int a = 0; a < 65536; a++) mem_bk[a] = 32'h1000_0000 | 32'(a);
        mem_bk[16'h0120] = 32'h0000_00A0;
        mem_bk[16'h0121] = 32'h0000_00A1;
        mem_bk[16'h0122] = 32'h0000_00A2;
        mem_bk[16'h0123] = 32'h0000_00A3;
        model_reset();
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_cpu_ready", {127'h0, cpu_ready}, 128'h1);
        chk("rst_cpu_ack", {127'h0, cpu_ack}, 128'h0);
        chk("rst_cpu_hit", {127'h0, cpu_hit}, 128'h0);
        chk("rst_cpu_rdata", {96'h0, cpu_rdata}, 128'h0);
        chk("rst_mem_req", {127'h0, mem_req}, 128'h0);
        chk("rst_mem_addr", {112'h0, mem_addr}, 128'h0);
        rst = 1'b0;

        // Cold read miss
        txn_log.delete();
        do_req(1'b0, 16'h0123, 32'h0, h, rd, lat);
        chk("cold_hit", {127'h0, h}, 128'h0);
        chk("cold_rdata", {96'h0, rd}, 128'hA3);
        chk("cold_txn_count", 128'(txn_log.size()), 128'h1);
        if (txn_log.size() == 1) begin
            chk("cold_fill_addr", {112'h0, txn_log[0].addr}, 128'h0120);
            chk("cold_fill_we", {127'h0, txn_log[0].we}, 128'h0);
        end
        do_req(1'b0, 16'h0121, 32'h0, h, rd, lat);
        chk("follow_hit", {127'h0, h}, 128'h1);
        chk("follow_rdata", {96'h0, rd}, 128'hA1);
        chk("hit_latency", 128'(lat), 128'h1);

        // Write hit then read back
        txn_log.delete();
        do_req(1'b1, 16'h0121, 32'hDEAD_BEEF, h, rd, lat);
        chk("wr_hit", {127'h0, h}, 128'h1);
        do_req(1'b0, 16'h0121, 32'h0, h, rd, lat);
        chk("rd_after_wr_hit", {127'h0, h}, 128'h1);
        chk("rd_after_wr_data", {96'h0, rd}, 128'hDEADBEEF);
        chk("wr_hit_no_mem", 128'(txn_log.size()), 128'h0);

        // LRU victim order in set 0: tags 1..4, touch tag 1, miss on tag 5
        do_req(1'b0, 16'h0040, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0080, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h00C0, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0100, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0040, 32'h0, h, rd, lat);
        chk("lru_touch_hit", {127'h0, h}, 128'h1);
        do_req(1'b0, 16'h0140, 32'h0, h, rd, lat);
        chk("lru_tag5_miss", {127'h0, h}, 128'h0);
        do_req(1'b0, 16'h0040, 32'h0, h, rd, lat);
        chk("lru_tag1_kept", {127'h0, h}, 128'h1);
        do_req(1'b0, 16'h0080, 32'h0, h, rd, lat);
        chk("lru_tag2_evicted", {127'h0, h}, 128'h0);

        // Dirty eviction: write 0x55 to word 2 of tag 10, then push it out with four new tags
        do_req(1'b1, 16'h0282, 32'h0000_0055, h, rd, lat);
        do_req(1'b0, 16'h02C0, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0300, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0340, 32'h0, h, rd, lat);
        txn_log.delete();
        do_req(1'b0, 16'h0380, 32'h0, h, rd, lat);
        chk("evict_hit", {127'h0, h}, 128'h0);
        chk("evict_txn_count", 128'(txn_log.size()), 128'h2);
        if (txn_log.size() == 2) begin
            chk("wb_we", {127'h0, txn_log[0].we}, 128'h1);
            chk("wb_addr", {112'h0, txn_log[0].addr}, 128'h0280);
            chk("wb_lane2", {96'h0, txn_log[0].data[95:64]}, 128'h55);
            chk("wb_lane0", {96'h0, txn_log[0].data[31:0]}, 128'h1000_0280);
            chk("fill_after_wb_we", {127'h0, txn_log[1].we}, 128'h0);
            chk("fill_after_wb_addr", {112'h0, txn_log[1].addr}, 128'h0380);
        end

        // Reset in the middle of a fill
        mem_hold = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 16'h1234;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        n = 0;
        while (!(mem_req && !mem_we) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midfill_req_seen", {127'h0, mem_req}, 128'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("midfill_req_drop", {127'h0, mem_req}, 128'h0);
        chk("midfill_ready_in_rst", {127'h0, cpu_ready}, 128'h1);
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
        mem_hold = 1'b0;
        #1;
        chk("ready_after_rst", {127'h0, cpu_ready}, 128'h1);
        do_req(1'b0, 16'h0121, 32'h0, h, rd, lat);
        chk("post_rst_miss", {127'h0, h}, 128'h0);
        chk("post_rst_rdata", {96'h0, rd}, 128'hA1);

`ifdef CACHE_STATS_EN
        do_reset();
        do_req(1'b0, 16'h0000, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0040, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0080, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0001, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0002, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0041, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0081, 32'h0, h, rd, lat);
        do_req(1'b0, 16'h0003, 32'h0, h, rd, lat);
        repeat (2) @(negedge clk);
        chk("stats_hit_cnt", {96'h0, hit_cnt}, 128'd5);
        chk("stats_miss_cnt", {96'h0, miss_cnt}, 128'd3);
`endif

        repeat (3) @(negedge clk);
        chk("final_cpu_expect_drained", 128'(exp_cpu.size()), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
